// File: rtl/cdc_cmd_scheduler.sv
// Round-robin command scheduler that serialises clk_in request pulses into
// one-at-a-time clk_out command strobes over a toggle req/ack handshake.
// Ports: clk_in/rst/clk_out clocks+sync reset; req_pulse in; pending, busy,
// grant_idx, done_pulse (clk_in); out_strobe, out_idx (clk_out).
// Optional: define CDC_CMD_COALESCE_CNT_EN to add coalesce_cnt[15:0] (clk_in).
module cdc_cmd_scheduler #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_out,
  input  logic [N_REQ-1:0] req_pulse,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             done_pulse,
`ifdef CDC_CMD_COALESCE_CNT_EN
  output logic [15:0]      coalesce_cnt,
`endif
  output logic             out_strobe,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                 state_q, state_d;
  logic [N_REQ-1:0]       pend_q, pend_d;
  logic [N_REQ-1:0]       gnt_oh;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       sel, cand;
  logic                   found;
  logic                   req_tgl_q, req_tgl_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_sync;

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   hist_q;
  logic                   ack_tgl_q;
  logic                   strobe_q;
  logic [IDX_W-1:0]       oidx_q;
  logic                   req_edge;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // Round-robin: first pending bit after the last grant.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | req_pulse;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    req_tgl_d = req_tgl_q;
    done_d    = 1'b0;
    gnt_oh    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_oh    = N_REQ'(1) << sel;
          // A same-cycle pulse on the granted bit re-queues it.
          pend_d    = (pend_q & ~gnt_oh) | req_pulse;
          grant_d   = sel;
          ptr_d     = sel;
          req_tgl_d = ~req_tgl_q;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_tgl_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      grant_q    <= '0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      req_tgl_q  <= 1'b0;
      done_q     <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      req_tgl_q  <= req_tgl_d;
      done_q     <= done_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
    end
  end

`ifdef CDC_CMD_COALESCE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        hit;

  assign hit = |(req_pulse & pend_q & ~gnt_oh);

  always_comb begin
    cnt_d = cnt_q;
    if (hit && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign coalesce_cnt = cnt_q;
`endif

  // grant_q is quasi-static while the toggle is in flight, so it is
  // sampled directly as the payload.
  assign req_edge = req_sync_q[SYNC_STAGES-1] ^ hist_q;

  always_ff @(posedge clk_out) begin
    if (rst) begin
      req_sync_q <= '0;
      hist_q     <= 1'b0;
      ack_tgl_q  <= 1'b0;
      strobe_q   <= 1'b0;
      oidx_q     <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
      hist_q     <= req_sync_q[SYNC_STAGES-1];
      strobe_q   <= req_edge;
      if (req_edge) begin
        oidx_q    <= grant_q;
        ack_tgl_q <= ~ack_tgl_q;
      end
    end
  end

  assign pending    = pend_q;
  assign busy       = (state_q == WAIT_ACK);
  assign grant_idx  = grant_q;
  assign done_pulse = done_q;
  assign out_strobe = strobe_q;
  assign out_idx    = oidx_q;

endmodule

// File: tb/tb_cdc_cmd_scheduler.sv
// Directed bench for cdc_cmd_scheduler: table of single-shot request
// patterns plus hand sequences for fairness, coalesce, re-queue and reset.
`timescale 1ns/1ps
module tb_cdc_cmd_scheduler;

  logic       clk_in = 1'b0;
  logic       clk_out = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_pulse = 4'b0;
  logic [3:0] pending;
  logic       busy;
  logic [1:0] grant_idx;
  logic       done_pulse;
  logic       out_strobe;
  logic [1:0] out_idx;
`ifdef CDC_CMD_COALESCE_CNT_EN
  logic [15:0] coalesce_cnt;
`endif

  realtime hp_in  = 5.0;
  realtime hp_out = 12.5;

  cdc_cmd_scheduler #(.N_REQ(4), .IDX_W(2), .SYNC_STAGES(2)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clk_out     (clk_out),
    .req_pulse   (req_pulse),
    .pending     (pending),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .done_pulse  (done_pulse),
`ifdef CDC_CMD_COALESCE_CNT_EN
    .coalesce_cnt(coalesce_cnt),
`endif
    .out_strobe  (out_strobe),
    .out_idx     (out_idx)
  );

  initial forever #(hp_in) clk_in = ~clk_in;
  initial forever #(hp_out) clk_out = ~clk_out;

  int n_cmp = 0;
  int n_err = 0;

  // Strobe / done monitors (sampled on the inactive edge).
  int         s_n = 0;
  int         d_n = 0;
  logic [1:0] s_idx [0:255];

  always @(negedge clk_out) begin
    if (out_strobe) begin
      s_idx[8'(s_n)] = out_idx;
      s_n = s_n + 1;
    end
  end

  always @(negedge clk_in) begin
    if (done_pulse) d_n = d_n + 1;
  end

  typedef struct {
    logic [3:0] req;
    int         n;
    logic [7:0] idx;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_pulse = 4'b0;
    repeat (8) @(posedge clk_out);
    repeat (8) @(posedge clk_in);
    #1 rst = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input logic [3:0] r);
    @(posedge clk_in);
    #1 req_pulse = r;
    @(posedge clk_in);
    #1 req_pulse = 4'b0;
  endtask

  task automatic wait_idle(input int n, input int b, input int bd,
                           input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(posedge clk_in);
      #1;
      ok = (s_n - b >= n) && (d_n - bd >= n) &&
           !busy && pending == 4'b0;
    end
    chk({nm, " drain"}, int'(ok), 1);
    repeat (12) @(posedge clk_out);
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_busy(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk_in);
      #1;
      ok = busy;
    end
    chk({nm, " busy"}, int'(ok), 1);
  endtask

  task automatic run_table(input string tag);
    int b;
    int bd;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      b  = s_n;
      bd = d_n;
      pulse(tv[i].req);
      wait_idle(tv[i].n, b, bd, $sformatf("%s v%0d", tag, i));
      chk($sformatf("%s v%0d strobes", tag, i), s_n - b, tv[i].n);
      chk($sformatf("%s v%0d dones", tag, i), d_n - bd, tv[i].n);
      for (int k = 0; k < tv[i].n && k < 4; k++)
        chk($sformatf("%s v%0d idx%0d", tag, i, k),
            int'(s_idx[8'(b + k)]), int'(tv[i].idx[2*k +: 2]));
      chk($sformatf("%s v%0d pending", tag, i), int'(pending), 0);
    end
  endtask

  task automatic mid_reset(input string tag);
    int b;
    int bd;
    do_reset();
    b  = s_n;
    bd = d_n;
    pulse(4'b0010);
    wait_busy(tag);
    do_reset();
    repeat (10) @(posedge clk_out);
    repeat (10) @(posedge clk_in);
    #1;
    chk({tag, " no strobe"}, s_n - b, 0);
    chk({tag, " no done"}, d_n - bd, 0);
    chk({tag, " pending"}, int'(pending), 0);
    chk({tag, " busy0"}, int'(busy), 0);
    chk({tag, " grant"}, int'(grant_idx), 0);
    chk({tag, " oidx"}, int'(out_idx), 0);
    chk({tag, " ostrobe"}, int'(out_strobe), 0);
    b  = s_n;
    bd = d_n;
    pulse(4'b1000);
    wait_idle(1, b, bd, {tag, " after"});
    chk({tag, " after n"}, s_n - b, 1);
    chk({tag, " after idx"}, int'(s_idx[8'(b)]), 3);
    chk({tag, " after done"}, d_n - bd, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int bd;
    bit ok;
    // idx packs expected order as {i3,i2,i1,i0}; index 0 wins first.
    tv[0] = '{req: 4'b0100, n: 1, idx: 8'b00_00_00_10};
    tv[1] = '{req: 4'b1001, n: 2, idx: 8'b00_00_11_00};
    tv[2] = '{req: 4'b1111, n: 4, idx: 8'b11_10_01_00};
    tv[3] = '{req: 4'b0110, n: 2, idx: 8'b00_00_10_01};
    tv[4] = '{req: 4'b1000, n: 1, idx: 8'b00_00_00_11};
    tv[5] = '{req: 4'b1010, n: 2, idx: 8'b00_00_11_01};

    do_reset();
    chk("rst pending", int'(pending), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst grant", int'(grant_idx), 0);
    chk("rst done", int'(done_pulse), 0);
    chk("rst strobe", int'(out_strobe), 0);
    chk("rst oidx", int'(out_idx), 0);
`ifdef CDC_CMD_COALESCE_CNT_EN
    chk("rst ccnt", int'(coalesce_cnt), 0);
`endif

    run_table("slow");

    // Fairness: all requesters re-pulse every cycle.
    do_reset();
    b = s_n;
    @(posedge clk_in);
    #1 req_pulse = 4'b1111;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(posedge clk_in);
      #1;
      ok = (s_n - b >= 12);
    end
    req_pulse = 4'b0;
    chk("fair reach12", int'(ok), 1);
    for (int k = 0; k < 12; k++)
      chk($sformatf("fair idx%0d", k), int'(s_idx[8'(b + k)]), k % 4);
    wait_idle(0, s_n, d_n, "fair");

    // Coalesce: req1 pulsed three times while req0 is in flight.
    do_reset();
    b  = s_n;
    bd = d_n;
    pulse(4'b0001);
    wait_busy("coal");
    @(posedge clk_in);
    #1 req_pulse = 4'b0010;
    repeat (3) @(posedge clk_in);
    #1 req_pulse = 4'b0;
    wait_idle(2, b, bd, "coal");
    chk("coal strobes", s_n - b, 2);
    chk("coal idx0", int'(s_idx[8'(b)]), 0);
    chk("coal idx1", int'(s_idx[8'(b + 1)]), 1);
`ifdef CDC_CMD_COALESCE_CNT_EN
    chk("coal cnt", int'(coalesce_cnt), 2);
`endif

    // Re-queue: req2 pulsed in the cycle it is granted.
    do_reset();
    b  = s_n;
    bd = d_n;
    @(posedge clk_in);
    #1 req_pulse = 4'b0100;
    repeat (2) @(posedge clk_in);
    #1 req_pulse = 4'b0;
    chk("rq pend kept", int'(pending[2]), 1);
    chk("rq busy", int'(busy), 1);
    chk("rq grant", int'(grant_idx), 2);
    wait_idle(2, b, bd, "rq");
    chk("rq strobes", s_n - b, 2);
    chk("rq idx0", int'(s_idx[8'(b)]), 2);
    chk("rq idx1", int'(s_idx[8'(b + 1)]), 2);
    chk("rq dones", d_n - bd, 2);
`ifdef CDC_CMD_COALESCE_CNT_EN
    chk("rq cnt", int'(coalesce_cnt), 0);
`endif

    mid_reset("midrst slow");

    // clk_in 20 MHz, clk_out 250 MHz.
    rst = 1'b1;
    hp_in  = 25.0;
    hp_out = 2.0;
    mid_reset("midrst fast");
    run_table("fast");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
